// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a multiplexed 3-digit 7-segment bus and recovers
// the displayed BCD digits and binary value, publishing only stable readings.
// Optional watchdog: define SCAN_TIMEOUT_EN to build the scan_lost timer.
module seg_scan_decoder #(
  parameter int unsigned SETTLE        = 4,
  parameter int unsigned STABLE_FRAMES = 2
`ifdef SCAN_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT       = 65535
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  input  logic [2:0] an,
  input  logic       alarm_in,
  output logic [3:0] bcd_h,
  output logic [3:0] bcd_t,
  output logic [3:0] bcd_u,
  output logic [9:0] value,
  output logic       valid,
  output logic       update,
  output logic       alarm,
  output logic       seg_err,
  output logic       an_err,
  output logic       scan_lost
);

  localparam int unsigned SEG_W = 7;
  localparam int unsigned AN_W  = 3;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned VAL_W = 10;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned STB_W = 4;

  typedef struct packed {
    logic [DIG_W-1:0] h;
    logic [DIG_W-1:0] t;
    logic [DIG_W-1:0] u;
  } digits_t;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

  logic [SEG_W-1:0] seg_m, seg_s, seg_p;
  logic [AN_W-1:0]  an_m, an_s, an_p;
  logic             alarm_m;

  state_t           state_q, state_c;
  logic [CNT_W-1:0] settle_q, settle_c;
  logic             sample_c;
  logic             changed_c;

  logic [DIG_W-1:0] dig_c;
  logic             seg_ok_c;
  logic             one_low_c;
  logic             good_c;
  logic             frame_done_c;
  logic             publish_c;
  logic             wd_fire_c;

  digits_t          cand_q, cand_c, prev_q;
  logic [AN_W-1:0]  mask_q, mask_c;
  logic [STB_W-1:0] stable_q, stable_c;
  logic [VAL_W-1:0] val_c;

  // Two-flop synchronisers plus one history stage for change detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_m   <= '0;
      seg_s   <= '0;
      seg_p   <= '0;
      an_m    <= '1;
      an_s    <= '1;
      an_p    <= '1;
      alarm_m <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      seg_m   <= seg;
      seg_s   <= seg_m;
      seg_p   <= seg_s;
      an_m    <= an;
      an_s    <= an_m;
      an_p    <= an_s;
      alarm_m <= alarm_in;
      alarm   <= alarm_m;
    end
  end

  assign changed_c = (an_s != an_p) || (seg_s != seg_p);

  // Scanner state and settle counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
    end else begin
      state_q  <= state_c;
      settle_q <= settle_c;
    end
  end

  // Scanner next state: one sample per anode dwell once the bus has settled
  always_comb begin
    state_c  = state_q;
    settle_c = settle_q;
    sample_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (an_s != 3'b111) begin
          state_c  = S_SETTLE;
          settle_c = '0;
        end
      end
      S_SETTLE: begin
        if (an_s == 3'b111) begin
          state_c  = S_IDLE;
          settle_c = '0;
        end else if (changed_c) begin
          settle_c = '0;
        end else if (settle_q == CNT_W'(SETTLE - 1)) begin
          sample_c = 1'b1;
          state_c  = S_HOLD;
          settle_c = '0;
        end else begin
          settle_c = settle_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (an_s != an_p) state_c = S_IDLE;
      end
      default: state_c = S_IDLE;
    endcase
  end

  // Segment pattern decode; blank reads as 0
  always_comb begin
    dig_c    = '0;
    seg_ok_c = 1'b1;
    case (seg_s)
      7'h3F, 7'h00: dig_c = 4'd0;
      7'h06:        dig_c = 4'd1;
      7'h5B:        dig_c = 4'd2;
      7'h4F:        dig_c = 4'd3;
      7'h66:        dig_c = 4'd4;
      7'h6D:        dig_c = 4'd5;
      7'h7D:        dig_c = 4'd6;
      7'h07:        dig_c = 4'd7;
      7'h7F:        dig_c = 4'd8;
      7'h6F:        dig_c = 4'd9;
      default:      seg_ok_c = 1'b0;
    endcase
  end

  assign one_low_c = (an_s == 3'b110) || (an_s == 3'b101) || (an_s == 3'b011);
  assign good_c    = sample_c && one_low_c && seg_ok_c;

  // Candidate frame assembly, stability tracking and publish decision
  always_comb begin
    cand_c = cand_q;
    if (good_c) begin
      case (an_s)
        3'b110:  cand_c.u = dig_c;
        3'b101:  cand_c.t = dig_c;
        default: cand_c.h = dig_c;
      endcase
    end
    mask_c       = mask_q | (good_c ? ~an_s : AN_W'(0));
    frame_done_c = good_c && (mask_c == 3'b111);
    if (cand_c == prev_q) begin
      stable_c = (stable_q == STB_W'(STABLE_FRAMES)) ? stable_q : stable_q + STB_W'(1);
    end else begin
      stable_c = STB_W'(1);
    end
    val_c = VAL_W'(cand_c.h) * VAL_W'(100) + VAL_W'(cand_c.t) * VAL_W'(10) + VAL_W'(cand_c.u);
    publish_c = frame_done_c && (stable_c == STB_W'(STABLE_FRAMES)) &&
                (!valid || (cand_c != {bcd_h, bcd_t, bcd_u}));
  end

  // Frame state, error pulses and published outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q   <= '0;
      prev_q   <= '0;
      mask_q   <= '0;
      stable_q <= '0;
      an_err   <= 1'b0;
      seg_err  <= 1'b0;
      update   <= 1'b0;
      valid    <= 1'b0;
      value    <= '0;
      bcd_h    <= '0;
      bcd_t    <= '0;
      bcd_u    <= '0;
    end else begin
      an_err  <= sample_c && !one_low_c;
      seg_err <= sample_c && one_low_c && !seg_ok_c;
      update  <= publish_c;
      if (wd_fire_c || (sample_c && one_low_c && !seg_ok_c)) begin
        mask_q   <= '0;
        stable_q <= '0;
      end else if (good_c) begin
        cand_q <= cand_c;
        if (frame_done_c) begin
          mask_q   <= '0;
          stable_q <= stable_c;
          prev_q   <= cand_c;
        end else begin
          mask_q <= mask_c;
        end
      end
      if (publish_c) begin
        bcd_h <= cand_c.h;
        bcd_t <= cand_c.t;
        bcd_u <= cand_c.u;
        value <= val_c;
        valid <= 1'b1;
      end
    end
  end

`ifdef SCAN_TIMEOUT_EN
  localparam int unsigned WD_W = 16;
  logic [WD_W-1:0] wd_q;

  assign wd_fire_c = !scan_lost && !good_c && (wd_q == WD_W'(TIMEOUT - 1));

  // Watchdog: cycles since the last good sample, stops once scan is lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q      <= '0;
      scan_lost <= 1'b0;
    end else if (good_c) begin
      wd_q      <= '0;
      scan_lost <= 1'b0;
    end else if (wd_fire_c) begin
      scan_lost <= 1'b1;
    end else if (!scan_lost) begin
      wd_q <= wd_q + WD_W'(1);
    end
  end
`else
  assign wd_fire_c = 1'b0;
  assign scan_lost = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (SETTLE=4, STABLE_FRAMES=2).
module tb_seg_scan_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg;
  logic [2:0] an;
  logic       alarm_in;
  logic [3:0] bcd_h, bcd_t, bcd_u;
  logic [9:0] value;
  logic       valid, update, alarm, seg_err, an_err, scan_lost;

  int n_checks = 0;
  int n_fail   = 0;
  int upd_cnt  = 0;
  int serr_cnt = 0;
  int aerr_cnt = 0;
  int u0, s0, a0;

  seg_scan_decoder #(
    .SETTLE(4),
    .STABLE_FRAMES(2)
`ifdef SCAN_TIMEOUT_EN
    ,
    .TIMEOUT(100)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .an(an), .alarm_in(alarm_in),
    .bcd_h(bcd_h), .bcd_t(bcd_t), .bcd_u(bcd_u), .value(value),
    .valid(valid), .update(update), .alarm(alarm), .seg_err(seg_err),
    .an_err(an_err), .scan_lost(scan_lost)
  );

  always #5 clk = ~clk;

  // Pulse counters
  always @(posedge clk) begin
    if (update)  upd_cnt  <= upd_cnt + 1;
    if (seg_err) serr_cnt <= serr_cnt + 1;
    if (an_err)  aerr_cnt <= aerr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  default: return 7'h6F;
    endcase
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic show_digit(input logic [2:0] a, input logic [6:0] s, input int dwell);
    an  = a;
    seg = s;
    cycles(dwell);
    an  = 3'b111;
    seg = 7'h00;
    cycles(2);
  endtask

  task automatic scan_frame(input int h, input int t, input int u);
    show_digit(3'b110, seg_of(u), 20);
    show_digit(3'b101, seg_of(t), 20);
    show_digit(3'b011, seg_of(h), 20);
  endtask

  task automatic glitch_units(input int u);
    an = 3'b110;
    for (int k = 0; k < 7; k++) begin
      seg = seg_of(u);
      cycles(2);
      seg = 7'h49;
      cycles(1);
    end
    an  = 3'b111;
    seg = 7'h00;
    cycles(2);
  endtask

  initial begin
    rst_n = 1'b0; an = 3'b111; seg = 7'h00; alarm_in = 1'b0;
    cycles(3);
    check("rst_bcd",   {bcd_h, bcd_t, bcd_u}, 0);
    check("rst_value", value, 0);
    check("rst_flags", {valid, update, alarm, seg_err, an_err, scan_lost}, 0);
    rst_n = 1'b1;
    cycles(2);

    // Alarm passes through two flops
    alarm_in = 1'b1;
    cycles(1);
    check("alarm_d1", alarm, 0);
    cycles(1);
    check("alarm_d2", alarm, 1);
    alarm_in = 1'b0;
    cycles(3);
    check("alarm_low", alarm, 0);

    // 072 needs two identical frames, never republished
    u0 = upd_cnt;
    scan_frame(0, 7, 2);
    check("f072_1_upd", upd_cnt - u0, 0);
    check("f072_1_valid", valid, 0);
    scan_frame(0, 7, 2);
    check("f072_2_upd", upd_cnt - u0, 1);
    check("f072_bcd", {bcd_h, bcd_t, bcd_u}, 12'h072);
    check("f072_value", value, 72);
    check("f072_valid", valid, 1);
    scan_frame(0, 7, 2);
    check("f072_3_upd", upd_cnt - u0, 1);

    // 120 then 121 x3: publish after the second 121
    u0 = upd_cnt;
    scan_frame(1, 2, 0);
    scan_frame(1, 2, 1);
    check("f121_a_upd", upd_cnt - u0, 0);
    check("f121_a_value", value, 72);
    scan_frame(1, 2, 1);
    check("f121_b_upd", upd_cnt - u0, 1);
    check("f121_value", value, 121);
    check("f121_bcd", {bcd_h, bcd_t, bcd_u}, 12'h121);
    scan_frame(1, 2, 1);
    check("f121_c_upd", upd_cnt - u0, 1);

    // Undecodable units pattern, then two good frames of 345
    u0 = upd_cnt; s0 = serr_cnt;
    show_digit(3'b110, 7'h49, 20);
    show_digit(3'b101, seg_of(4), 20);
    show_digit(3'b011, seg_of(3), 20);
    check("serr_pulse", serr_cnt - s0, 1);
    check("serr_no_upd", upd_cnt - u0, 0);
    scan_frame(3, 4, 5);
    check("serr_good1_upd", upd_cnt - u0, 0);
    check("serr_good1_value", value, 121);
    scan_frame(3, 4, 5);
    check("serr_good2_upd", upd_cnt - u0, 1);
    check("serr_value", value, 345);

    // Two anodes low
    u0 = upd_cnt; s0 = serr_cnt; a0 = aerr_cnt;
    an = 3'b100; seg = seg_of(1);
    cycles(10);
    an = 3'b111; seg = 7'h00;
    cycles(3);
    check("an_err_pulse", aerr_cnt - a0, 1);
    check("an_err_no_serr", serr_cnt - s0, 0);
    check("an_err_no_upd", upd_cnt - u0, 0);

    // Segment glitch during units dwell prevents any units sample
    u0 = upd_cnt; s0 = serr_cnt;
    for (int f = 0; f < 3; f++) begin
      glitch_units(7);
      show_digit(3'b101, seg_of(8), 20);
      show_digit(3'b011, seg_of(9), 20);
    end
    check("glitch_no_upd", upd_cnt - u0, 0);
    check("glitch_no_serr", serr_cnt - s0, 0);
    check("glitch_value", value, 345);

    // Reset mid-frame
    show_digit(3'b110, seg_of(5), 20);
    show_digit(3'b101, seg_of(5), 20);
    an = 3'b011; seg = seg_of(5);
    cycles(3);
    rst_n = 1'b0;
    cycles(3);
    check("mid_rst_bcd", {bcd_h, bcd_t, bcd_u}, 0);
    check("mid_rst_value", value, 0);
    check("mid_rst_flags", {valid, update, alarm, seg_err, an_err, scan_lost}, 0);
    an = 3'b111; seg = 7'h00;
    rst_n = 1'b1;
    cycles(3);
    u0 = upd_cnt;
    scan_frame(5, 5, 5);
    check("post_rst_f1_upd", upd_cnt - u0, 0);
    check("post_rst_f1_valid", valid, 0);
    scan_frame(5, 5, 5);
    check("post_rst_f2_upd", upd_cnt - u0, 1);
    check("post_rst_value", value, 555);

`ifdef SCAN_TIMEOUT_EN
    // Watchdog with TIMEOUT=100, bus idle
    cycles(60);
    check("wd_not_yet", scan_lost, 0);
    cycles(90);
    check("wd_lost", scan_lost, 1);
    check("wd_keep_value", value, 555);
    check("wd_keep_valid", valid, 1);
    show_digit(3'b110, seg_of(5), 20);
    check("wd_cleared", scan_lost, 0);
`else
    cycles(150);
    check("no_wd", scan_lost, 0);
    check("no_wd_value", value, 555);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
